// File: rtl/radix2_fft4_stream.sv
// Streaming 4-point radix-2 FFT/IFFT.
// Loads four complex samples, runs two butterfly stages (one cycle each), then
// unloads bins X0..X3 in natural order under valid/ready handshaking.
// Full bit growth: DW-bit inputs, DW+1-bit stage-1 values, DW+2-bit bins.
module radix2_fft4_stream #(
  parameter int unsigned DW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inverse,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW+1:0] out_re,
  output logic signed [DW+1:0] out_im,
  output logic [1:0]           out_idx,
  output logic                 out_last,
  output logic                 frame_err
);

  typedef enum logic [1:0] {StLoad, StCalc1, StCalc2, StUnload} state_e;

  state_e          state_q;
  logic [1:0]      cnt_q;
  logic            inv_q;
  logic [DW-1:0]   x_re_q [4];
  logic [DW-1:0]   x_im_q [4];

  // Stage-1 butterfly results
  logic [DW:0]     a_re_q, a_im_q, b_re_q, b_im_q, c_re_q, c_im_q, d_re_q, d_im_q;
  logic [DW:0]     a_re_d, a_im_d, b_re_d, b_im_d, c_re_d, c_im_d, d_re_d, d_im_d;

  // Output bins
  logic [DW+1:0]   bin_re_q [4];
  logic [DW+1:0]   bin_im_q [4];
  logic [DW+1:0]   bin_re_d [4];
  logic [DW+1:0]   bin_im_d [4];

  logic [DW+1:0]   fwd1_re, fwd1_im, fwd3_re, fwd3_im;

  logic            out_valid_q;
  logic [1:0]      out_idx_q;
  logic [DW+1:0]   out_re_q, out_im_q;
  logic            frame_err_q;

  logic            accept;
  logic [1:0]      nxt_idx;

  // Sign extension by one bit; two's-complement add/sub is then overflow-free.
  function automatic logic [DW:0] ext1(input logic [DW-1:0] v);
    return {v[DW-1], v};
  endfunction

  function automatic logic [DW+1:0] ext2(input logic [DW:0] v);
    return {v[DW], v};
  endfunction

  assign in_ready  = (state_q == StLoad);
  assign accept    = in_valid && in_ready;
  assign nxt_idx   = out_idx_q + 2'd1;

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_last  = (out_idx_q == 2'd3);
  assign frame_err = frame_err_q;

  // Stage-1 butterflies on the stored samples
  always_comb begin
    a_re_d = ext1(x_re_q[0]) + ext1(x_re_q[2]);
    a_im_d = ext1(x_im_q[0]) + ext1(x_im_q[2]);
    b_re_d = ext1(x_re_q[0]) - ext1(x_re_q[2]);
    b_im_d = ext1(x_im_q[0]) - ext1(x_im_q[2]);
    c_re_d = ext1(x_re_q[1]) + ext1(x_re_q[3]);
    c_im_d = ext1(x_im_q[1]) + ext1(x_im_q[3]);
    d_re_d = ext1(x_re_q[1]) - ext1(x_re_q[3]);
    d_im_d = ext1(x_im_q[1]) - ext1(x_im_q[3]);
  end

  // Stage-2 butterflies; inverse swaps the roles of X1 and X3 (no 1/N scaling)
  always_comb begin
    fwd1_re = ext2(b_re_q) + ext2(d_im_q);
    fwd1_im = ext2(b_im_q) - ext2(d_re_q);
    fwd3_re = ext2(b_re_q) - ext2(d_im_q);
    fwd3_im = ext2(b_im_q) + ext2(d_re_q);
    bin_re_d[0] = ext2(a_re_q) + ext2(c_re_q);
    bin_im_d[0] = ext2(a_im_q) + ext2(c_im_q);
    bin_re_d[2] = ext2(a_re_q) - ext2(c_re_q);
    bin_im_d[2] = ext2(a_im_q) - ext2(c_im_q);
    bin_re_d[1] = inv_q ? fwd3_re : fwd1_re;
    bin_im_d[1] = inv_q ? fwd3_im : fwd1_im;
    bin_re_d[3] = inv_q ? fwd1_re : fwd3_re;
    bin_im_d[3] = inv_q ? fwd1_im : fwd3_im;
  end

  // Frame FSM with sample store, pipeline registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StLoad;
      cnt_q       <= 2'd0;
      inv_q       <= 1'b0;
      a_re_q      <= '0;
      a_im_q      <= '0;
      b_re_q      <= '0;
      b_im_q      <= '0;
      c_re_q      <= '0;
      c_im_q      <= '0;
      d_re_q      <= '0;
      d_im_q      <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= 2'd0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        x_re_q[i]   <= '0;
        x_im_q[i]   <= '0;
        bin_re_q[i] <= '0;
        bin_im_q[i] <= '0;
      end
    end else begin
      frame_err_q <= 1'b0;
      unique case (state_q)
        StLoad: begin
          if (accept) begin
            x_re_q[cnt_q] <= in_re;
            x_im_q[cnt_q] <= in_im;
            if (cnt_q == 2'd0) inv_q <= inverse;
            // The counter, not in_last, defines the frame boundary
            frame_err_q   <= (in_last != (cnt_q == 2'd3));
            cnt_q         <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_q <= StCalc1;
          end
        end
        StCalc1: begin
          a_re_q  <= a_re_d;
          a_im_q  <= a_im_d;
          b_re_q  <= b_re_d;
          b_im_q  <= b_im_d;
          c_re_q  <= c_re_d;
          c_im_q  <= c_im_d;
          d_re_q  <= d_re_d;
          d_im_q  <= d_im_d;
          state_q <= StCalc2;
        end
        StCalc2: begin
          for (int i = 0; i < 4; i++) begin
            bin_re_q[i] <= bin_re_d[i];
            bin_im_q[i] <= bin_im_d[i];
          end
          out_re_q    <= bin_re_d[0];
          out_im_q    <= bin_im_d[0];
          out_idx_q   <= 2'd0;
          out_valid_q <= 1'b1;
          state_q     <= StUnload;
        end
        StUnload: begin
          if (out_ready) begin
            if (out_idx_q == 2'd3) begin
              // Outputs keep their last values until the next frame is ready
              out_valid_q <= 1'b0;
              state_q     <= StLoad;
            end else begin
              out_idx_q <= nxt_idx;
              out_re_q  <= bin_re_q[nxt_idx];
              out_im_q  <= bin_im_q[nxt_idx];
            end
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

endmodule

// File: tb/tb_radix2_fft4_stream.sv
// Directed bench for radix2_fft4_stream (DW=8) with hand-computed bins.
module tb_radix2_fft4_stream;

  localparam int DW = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 inverse = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_re = '0;
  logic signed [DW-1:0] in_im = '0;
  logic                 in_last = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [DW+1:0] out_re;
  logic signed [DW+1:0] out_im;
  logic [1:0]           out_idx;
  logic                 out_last;
  logic                 frame_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int zero4[4]    = '{0, 0, 0, 0};
  int imp_re[4]   = '{1, 0, 0, 0};
  int ones4[4]    = '{1, 1, 1, 1};
  int ramp_re[4]  = '{1, 2, 3, 4};
  int rampx_re[4] = '{10, -2, -2, -2};
  int rampf_im[4] = '{0, 2, 0, -2};
  int rampi_im[4] = '{0, -2, 0, 2};
  int ext_re[4]   = '{-128, -128, -128, -128};
  int ext_im[4]   = '{127, 127, 127, 127};
  int extx_re[4]  = '{-512, 0, 0, 0};
  int extx_im[4]  = '{508, 0, 0, 0};

  radix2_fft4_stream #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inverse   (inverse),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame; inverse is flipped after sample 0 to show it is latched.
  task automatic send_frame(input int re[4], input int im[4], input logic inv,
                            input int last_pos, output int t0);
    int w;
    t0 = 0;
    for (int i = 0; i < 4; i++) begin
      w        = 0;
      in_valid = 1'b1;
      in_re    = re[i][DW-1:0];
      in_im    = im[i][DW-1:0];
      in_last  = (i == last_pos);
      inverse  = (i == 0) ? inv : ~inv;
      while (!in_ready && w < 40) begin
        tick();
        w++;
      end
      chk($sformatf("in_ready_wait[%0d]", i), in_ready, 1);
      if (i == 0) t0 = cyc;
      tick();
      chk($sformatf("frame_err[%0d]", i), frame_err, ((i == last_pos) != (i == 3)));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Collects bins k0..3 with out_ready high and checks every output field.
  task automatic recv_frame(input int er[4], input int ei[4], input int k0);
    int w;
    out_ready = 1'b1;
    for (int k = k0; k < 4; k++) begin
      w = 0;
      while (!out_valid && w < 40) begin
        tick();
        w++;
      end
      chk($sformatf("out_valid[%0d]", k), out_valid, 1);
      chk($sformatf("out_idx[%0d]", k), out_idx, k);
      chk($sformatf("out_re[%0d]", k), out_re, er[k]);
      chk($sformatf("out_im[%0d]", k), out_im, ei[k]);
      chk($sformatf("out_last[%0d]", k), out_last, (k == 3));
      tick();
    end
    chk("valid_after_idx3", out_valid, 0);
    chk("in_ready_after_idx3", in_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0a, t0b, w;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_re", out_re, 0);
    chk("rst_out_im", out_im, 0);
    chk("rst_frame_err", frame_err, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Impulse, forward, with latency check
    send_frame(imp_re, zero4, 1'b0, 3, t0a);
    chk("calc1_in_ready", in_ready, 0);
    chk("calc1_out_valid", out_valid, 0);
    tick();
    chk("calc2_out_valid", out_valid, 0);
    chk("calc2_in_ready", in_ready, 0);
    chk("frame_err_one_cycle", frame_err, 0);
    tick();
    chk("latency_out_valid", out_valid, 1);
    recv_frame(ones4, zero4, 0);

    // Ramp forward and inverse
    send_frame(ramp_re, zero4, 1'b0, 3, t0a);
    recv_frame(rampx_re, rampf_im, 0);
    send_frame(ramp_re, zero4, 1'b1, 3, t0a);
    recv_frame(rampx_re, rampi_im, 0);

    // Extremes
    send_frame(ext_re, ext_im, 1'b0, 3, t0a);
    recv_frame(extx_re, extx_im, 0);

    // Backpressure at idx 1
    out_ready = 1'b0;
    send_frame(ramp_re, zero4, 1'b0, 3, t0a);
    w = 0;
    while (!out_valid && w < 40) begin
      tick();
      w++;
    end
    chk("bp_idx0", out_idx, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_idx", out_idx, 1);
      chk("bp_hold_re", out_re, -2);
      chk("bp_hold_im", out_im, 2);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    recv_frame(rampx_re, rampf_im, 1);

    // Framing error: in_last on sample 2
    send_frame(ramp_re, zero4, 1'b0, 2, t0a);
    recv_frame(rampx_re, rampf_im, 0);

    // Back-to-back frames, 10-cycle period
    out_ready = 1'b1;
    send_frame(ramp_re, zero4, 1'b0, 3, t0a);
    send_frame(ext_re, ext_im, 1'b0, 3, t0b);
    chk("frame_period", t0b - t0a, 10);
    recv_frame(extx_re, extx_im, 0);

    // Reset mid-LOAD: two stray samples, then a clean inverse frame
    in_valid = 1'b1;
    in_re    = 8'sd50;
    in_im    = -8'sd7;
    tick();
    tick();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rst_load_in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_frame(ramp_re, zero4, 1'b1, 3, t0a);
    recv_frame(rampx_re, rampi_im, 0);

    // Reset mid-UNLOAD at idx 2
    send_frame(ramp_re, zero4, 1'b0, 3, t0a);
    out_ready = 1'b1;
    w = 0;
    while (!out_valid && w < 40) begin
      tick();
      w++;
    end
    tick();
    tick();
    out_ready = 1'b0;
    chk("pre_rst_idx2", out_idx, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_unload_valid", out_valid, 0);
    chk("rst_unload_in_ready", in_ready, 1);
    chk("rst_unload_idx", out_idx, 0);
    chk("rst_unload_re", out_re, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst_no_stale", out_valid, 0);
    send_frame(ext_re, ext_im, 1'b0, 3, t0a);
    recv_frame(extx_re, extx_im, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/radix2_fft4_stream.md
RADIX2_FFT4_STREAM -- requirements
Module: radix2_fft4_stream

Interface
REQ-001 The module SHALL have a parameter DW, default 8, giving the signed two's-complement width of each input real/imag component.
REQ-002 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 inverse  input  1  transform direction: 0 forward, 1 inverse; sampled with the first sample of each frame.
REQ-006 in_valid  input  1  in_re/in_im/in_last carry a sample.
REQ-007 in_ready  output  1  block accepts a sample this cycle.
REQ-008 in_re, in_im  input  DW each  signed input sample x[n], real and imaginary parts.
REQ-009 in_last  input  1  producer's marker for the 4th sample of a frame.
REQ-010 out_valid  output  1  out_re/out_im/out_idx/out_last hold a result.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 out_re, out_im  output  DW+2 each  signed bin X[k], real and imaginary parts.
REQ-013 out_idx  output  2  bin index k of the current output.
REQ-014 out_last  output  1  high when out_idx==3.
REQ-015 frame_err  output  1  one-cycle pulse on an in_last framing mismatch.

Function
REQ-016 The FSM SHALL have the states LOAD, CALC1, CALC2 and UNLOAD.
REQ-017 in_ready SHALL equal 1 only in LOAD; a sample is accepted when in_valid && in_ready.
REQ-018 A 2-bit input counter SHALL store accepted samples as x0..x3 in arrival order and wrap from 3 to 0.
REQ-019 inverse SHALL be latched when sample 0 is accepted and held for the whole frame.
REQ-020 Acceptance of sample 3 SHALL move LOAD to CALC1, regardless of in_last.
REQ-021 frame_err SHALL pulse in the cycle after any accept where in_last differs from (counter==3); the frame is still processed on the counter.
REQ-022 CALC1 (one cycle) SHALL register the complex values a=x0+x2, b=x0-x2, c=x1+x3, d=x1-x3 at DW+1 bits, then move to CALC2.
REQ-023 CALC2 (one cycle) SHALL register the DW+2-bit bins: X0=a+c; X2=a-c.
REQ-024 In forward mode, CALC2 SHALL register X1=b-j*d (re=b.re+d.im, im=b.im-d.re) and X3=b+j*d (re=b.re-d.im, im=b.im+d.re).
REQ-025 In inverse mode, CALC2 SHALL swap the X1 and X3 expressions of REQ-024 and SHALL apply no 1/N scaling.
REQ-026 All arithmetic SHALL be sign-extended with full growth, so no overflow, saturation or rounding is possible.
REQ-027 After CALC2 the block SHALL enter UNLOAD with out_valid=1, out_idx=0 and out_re/out_im=X0.
REQ-028 Each out_valid && out_ready SHALL advance out_idx by 1 in natural order X0..X3.
REQ-029 With out_ready=0, all outputs SHALL stay stable.
REQ-030 Transfer of idx 3 SHALL clear out_valid and return the FSM to LOAD; in_ready rises in the next cycle.
REQ-031 Latency: 4th input accepted at edge k -> out_valid high after edge k+2.
REQ-032 Minimum frame period with out_ready=1 SHALL be 4 (load) + 2 (calc) + 4 (unload) = 10 cycles.
REQ-033 Outside UNLOAD, out_re/out_im/out_idx SHALL hold their last values while out_valid=0.

Reset
REQ-034 rst_n=0 SHALL immediately force: state LOAD, input counter 0, in_ready=1, out_valid=0, out_idx=0, out_last=0, out_re=0, out_im=0, frame_err=0, latched inverse=0.
REQ-035 Reset asserted in any state, including mid-LOAD or mid-UNLOAD, SHALL discard the partial frame; no stale output appears after release.
REQ-036 After release, the first accepted sample SHALL be x0 of a new frame.

Verification (DW=8)
REQ-037 Impulse: forward, x=(1,0,0,0) -> X0..X3 all re=1, im=0; out_last only on idx 3.
REQ-038 Ramp: forward, real x=(1,2,3,4) -> X0=10, X1=-2+2j, X2=-2, X3=-2-2j. With inverse=1 -> X1=-2-2j, X3=-2+2j.
REQ-039 Extremes: all samples re=-128, im=127 -> X0=-512+508j, X1=X2=X3=0; no wrap.
REQ-040 Backpressure: out_ready=0 for 5 cycles at idx 1 -> out_idx/out_re/out_im held; in_ready=0 throughout CALC1..UNLOAD; next frame accepted only after the idx 3 transfer.
REQ-041 Framing: in_last on sample 2 -> frame_err pulses twice (samples 2 and 3), results still correct. Back-to-back frames with in_valid=1 and out_ready=1 -> 10-cycle period.
REQ-042 Reset mid-UNLOAD at idx 2 -> out_valid=0 immediately, in_ready=1; the next frame gives correct results.
